// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter; define ARB_TIMEOUT_EN to build the grant-hold timeout
module rr_arbiter8 #(
    parameter int N       = 8,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d, arb_req;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d, ptr_q, ptr_d, arb_ptr, next_ptr, win_idx;
    logic            gnt_valid_q, gnt_valid_d, timeout_q, timeout_d;
    logic            rel, upd, force_rel, win_found;
    if (IDXW != $clog2(N) || N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("rr_arbiter8: illegal parameter combination");
    end
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    // forced release only when the owner would otherwise keep the grant
    assign force_rel = state_q == BUSY && cnt_q == CW'(TIMEOUT - 1) && !done && req[gnt_idx_q];
`else
    assign force_rel = 1'b0;
`endif
    // first requester at or after arb_ptr in cyclic ascending order
    always_comb begin
        int k;
        k         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(arb_ptr) + i;
            k = k >= N ? k - N : k;
            if (!win_found && arb_req[k]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(k);
            end
        end
    end
    // release detection, pointer advance and next grant selection
    always_comb begin
        rel         = state_q == BUSY && (done || !req[gnt_idx_q] || force_rel);
        upd         = state_q == IDLE || rel;
        next_ptr    = gnt_idx_q == IDXW'(N - 1) ? '0 : gnt_idx_q + 1'b1;
        arb_ptr     = rel ? next_ptr : ptr_q;
        arb_req     = rel ? req & ~gnt_q : (state_q == IDLE ? req : '0);
        ptr_d       = arb_ptr;
        state_d     = upd ? (win_found ? BUSY : IDLE) : BUSY;
        gnt_d       = upd ? (win_found ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0) : gnt_q;
        gnt_idx_d   = upd ? win_idx : gnt_idx_q;
        gnt_valid_d = upd ? win_found : gnt_valid_q;
        timeout_d   = force_rel;
    end
`ifdef ARB_TIMEOUT_EN
    // hold counter restarts on every new grant
    always_comb begin
        cnt_d = upd ? '0 : cnt_q + 1'b1;
    end
    // hold counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif
    // arbiter state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of rr_arbiter8 grant order, handoff, release and reset
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    int         tests = 0;
    int         fails = 0;

    rr_arbiter8 dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset c%0d: gnt=%h idx=%0d v=%b to=%b want 00/0/0/0", c, gnt, gnt_idx, gnt_valid, timeout);
            end
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_release: gnt=%h idx=%0d v=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp;
        for (int i = 1; i <= 8; i++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            exp = 8'h01 << (i % 8);
            tests++;
            if ({gnt, gnt_idx, gnt_valid} !== {exp, 3'(i % 8), 1'b1}) begin
                fails++;
                $display("FAIL rotation %0d: gnt=%h idx=%0d v=%b want %h/%0d/1", i, gnt, gnt_idx, gnt_valid, exp, i % 8);
            end
        end
    endtask

    task automatic test_ptr_priority();
        req = 8'h10;
        tick();
        tests++;
        if ({gnt, gnt_idx} !== {8'h10, 3'd4}) begin
            fails++;
            $display("FAIL serve4: gnt=%h idx=%0d want 10/4", gnt, gnt_idx);
        end
        req = 8'b0000_0101;
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL ptr5_pick0: gnt=%h idx=%0d v=%b want 01/0/1", gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
            fails++;
            $display("FAIL ptr1_pick2: gnt=%h idx=%0d v=%b want 04/2/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_withdraw();
        req = 8'h08;
        tick();
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL owner3_hold: gnt=%h idx=%0d v=%b want 08/3/1", gnt, gnt_idx, gnt_valid);
        end
        req = 8'h00;
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL withdraw: gnt=%h idx=%0d v=%b want 00/0/0", gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++;
        if ({gnt, gnt_valid} !== {8'h00, 1'b0}) begin
            fails++;
            $display("FAIL idle_done: gnt=%h v=%b want 00/0", gnt, gnt_valid);
        end
        req = 8'h08;
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL regrant3: gnt=%h idx=%0d v=%b want 08/3/1", gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tests++;
        if ({gnt, gnt_valid} !== {8'h00, 1'b0}) begin
            fails++;
            $display("FAIL lone_idle_gap: gnt=%h v=%b want 00/0", gnt, gnt_valid);
        end
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL lone_rewin: gnt=%h idx=%0d v=%b want 08/3/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h40;
        tick();
        tests++;
        if ({gnt, gnt_idx} !== {8'h40, 3'd6}) begin
            fails++;
            $display("FAIL owner6: gnt=%h idx=%0d want 40/6", gnt, gnt_idx);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: gnt=%h idx=%0d v=%b want 00/0/0", gnt, gnt_idx, gnt_valid);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({gnt, gnt_idx, gnt_valid} !== {8'h40, 3'd6, 1'b1}) begin
            fails++;
            $display("FAIL post_reset6: gnt=%h idx=%0d v=%b want 40/6/1", gnt, gnt_idx, gnt_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'h81;
        tick();
        tests++;
        if ({gnt, gnt_idx} !== {8'h01, 3'd0}) begin
            fails++;
            $display("FAIL ptr_reset: gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
        end
    endtask

    task automatic test_hold();
        rst = 1'b1; done = 1'b0;
        tick();
        rst = 1'b0;
        req = 8'h03;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 16; c++) begin
            tick();
            tests++;
            if ({gnt, timeout} !== {8'h01, 1'b0}) begin
                fails++;
                $display("FAIL hold c%0d: gnt=%h to=%b want 01/0", c, gnt, timeout);
            end
        end
        tick();
        tests++;
        if ({gnt, gnt_idx, timeout} !== {8'h02, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL forced_release: gnt=%h idx=%0d to=%b want 02/1/1", gnt, gnt_idx, timeout);
        end
        tick();
        tests++;
        if ({gnt, timeout} !== {8'h02, 1'b0}) begin
            fails++;
            $display("FAIL timeout_pulse: gnt=%h to=%b want 02/0", gnt, timeout);
        end
`else
        for (int c = 0; c < 100; c++) begin
            tests++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL hold c%0d: gnt=%h idx=%0d v=%b to=%b want 01/0/1/0", c, gnt, gnt_idx, gnt_valid, timeout);
            end
            tick();
        end
`endif
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        test_reset();
        test_rotation();
        test_ptr_priority();
        test_withdraw();
        test_reset_mid_grant();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among N requesters (default 8, matching the team's 8-bit priority-encoder datapath).
- Uses rotating-priority encoding to pick one winner per arbitration and registers a one-hot grant plus its binary index.
- Holds the grant until the resource signals completion or the owner withdraws its request.
- Sits between the request sources and the shared resource.

Parameters:
N, 8, number of requesters (2..16)
IDXW, 3, width of grant index; must equal ceil(log2(N))
TIMEOUT, 16, maximum grant hold in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  N  request vector; bit k = requester k wants the resource
done  input  1  resource finished the current owner's transaction; sampled only while gnt_valid=1
gnt  output  N  registered one-hot grant; all zero when idle
gnt_idx  output  IDXW  registered binary index of current owner; 0 when idle
gnt_valid  output  1  registered; high while any grant is held
timeout  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only); tied 0 otherwise

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: sampled on a clk edge with rst=1. Result: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, state=IDLE, hold counter=0.
- Reset mid-grant drops the grant on that same edge; no done is required.
- Internal pointer ptr[IDXW-1:0] names the highest-priority requester.
- Priority order: ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (cyclic, ascending).
- Winner: first set bit of req in priority order, from a combinational rotate + priority-encode + rotate-back.
- State IDLE:
  - gnt_valid=0.
  - If |req=1, the winner is registered on the next edge: gnt=onehot(w), gnt_idx=w, gnt_valid=1, state goes to BUSY.
  - Latency is exactly one cycle from req sampled high to grant visible.
  - If req=0, remain in IDLE.
- State BUSY:
  - gnt and gnt_idx are held stable.
  - Changes on other req bits are ignored.
- Release condition, sampled in BUSY: done=1 OR req[gnt_idx]=0.
- On the release edge:
  - ptr <= (gnt_idx+1) mod N.
  - Re-arbitrate in the same edge using the new ptr over the current req, with the releasing owner's bit masked.
  - If any other request exists, the new grant appears on the next cycle with no idle gap (back-to-back handoff) and state stays BUSY.
  - Otherwise gnt=0, gnt_valid=0, state goes to IDLE.
  - A lone owner that still requests may win again only after one IDLE cycle.
- Pointer wrap: an owner at index N-1 sets ptr=0.
- Simultaneous done=1 and req[gnt_idx]=0: a single release, identical to either alone.
- done while IDLE is ignored.
- Invariants: gnt is always zero or one-hot; gnt_valid == |gnt; gnt_idx matches gnt whenever gnt_valid=1.
- Starvation bound: every continuously asserted requester is granted within N grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A hold counter clears on every new grant and increments each BUSY cycle.
  - When it reaches TIMEOUT-1 with no release, the next edge forces a release, exactly as if done=1 (pointer advance and handoff included).
  - timeout pulses high for that one cycle.
- When undefined:
  - No counter is built, timeout is constant 0, and a grant may be held indefinitely.

Test Plan:
- rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0 throughout. Release rst -> one cycle later gnt=8'h01, gnt_idx=0.
- req=8'hFF held; pulse done once per grant -> grant sequence 0,1,2,...,7,0 (gnt=01,02,04,...,80,01) with no idle cycle between grants; gnt_idx wraps 7->0.
- ptr=5 (after serving owner 4), req=8'b0000_0101 -> grant goes to 0, not 2. Then done -> grant goes to 2 next cycle.
- Owner 3 holds grant with req=8'h08 and done=0; drop req[3] -> gnt=0 and gnt_valid=0 next cycle. Then req=8'h08 again -> granted after one IDLE cycle.
- rst asserted for one cycle while owner 6 is granted -> gnt=0 at that edge. Deassert with req=8'h40 -> gnt=8'h40 one cycle later (ptr=0).
- ARB_TIMEOUT_EN, TIMEOUT=16, req=8'h03, done held 0 -> owner 0 forced off after 16 grant cycles with timeout=1 for one cycle; gnt=8'h02 on the next cycle. Without the macro, gnt=8'h01 stays for 100 cycles and timeout=0.
